// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launches programs 1..NUM_PROGS back to back, times each run, aborts a runaway
`timescale 1ns/1ps
module prog_sequencer #(
  parameter int NUM_PROGS = 3,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Done,
  output logic             Start,
  output logic [3:0]       ProgIdx,
  output logic             Busy,
  output logic             ResultValid,
  output logic [3:0]       ResultProg,
  output logic [CNT_W-1:0] ResultCycles,
  output logic             AllDone,
  output logic             Error
);

  localparam logic [3:0]       LAST_PROG = NUM_PROGS[3:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, FINISH} seqStateT;

  seqStateT         state, stateNext;
  logic [CNT_W-1:0] counter, counterNext;
  logic [3:0]       progIdxNext;
  logic             errorNext;
  logic             resultValidNext;
  logic [3:0]       resultProgNext;
  logic [CNT_W-1:0] resultCyclesNext;

  // Next-state and next-output decode; Done beats the timeout when both land on one edge
  always_comb begin
    stateNext        = state;
    counterNext      = counter;
    progIdxNext      = ProgIdx;
    errorNext        = Error;
    resultValidNext  = 1'b0;
    resultProgNext   = ResultProg;
    resultCyclesNext = ResultCycles;
    case (state)
      IDLE: begin
        if (Go) begin
          progIdxNext = 4'd1;
          errorNext   = 1'b0;
          stateNext   = LAUNCH;
        end
      end
      LAUNCH: begin
        counterNext = '0;
        stateNext   = RUN;
      end
      RUN: begin
        if (Done) begin
          resultCyclesNext = counter;
          resultProgNext   = ProgIdx;
          resultValidNext  = 1'b1;
          stateNext        = (ProgIdx == LAST_PROG) ? FINISH : GAP;
        end else if (counter == CNT_MAX) begin
          errorNext = 1'b1;
          stateNext = FINISH;
        end else begin
          counterNext = counter + 1'b1;
        end
      end
      GAP: begin
        progIdxNext = ProgIdx + 4'd1;
        stateNext   = LAUNCH;
      end
      FINISH: begin
        if (!Go) begin
          progIdxNext = 4'd0;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counter and registered outputs; status flags follow the state being entered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      counter      <= '0;
      Start        <= 1'b0;
      ProgIdx      <= 4'd0;
      Busy         <= 1'b0;
      ResultValid  <= 1'b0;
      ResultProg   <= 4'd0;
      ResultCycles <= '0;
      AllDone      <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= stateNext;
      counter      <= counterNext;
      Start        <= (stateNext == LAUNCH);
      ProgIdx      <= progIdxNext;
      Busy         <= (stateNext == LAUNCH) || (stateNext == RUN) || (stateNext == GAP);
      ResultValid  <= resultValidNext;
      ResultProg   <= resultProgNext;
      ResultCycles <= resultCyclesNext;
      AllDone      <= (stateNext == FINISH);
      Error        <= errorNext;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - table-driven and scoreboard bench for prog_sequencer
`timescale 1ns/1ps
module tb_prog_sequencer;
  localparam int NP = 3;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b1;
  logic          holdDone = 1'b0;
  logic          pulseDone = 1'b0;
  logic          Done;
  logic          Start, Busy, ResultValid, AllDone, Error;
  logic [3:0]    ProgIdx, ResultProg;
  logic [CW-1:0] ResultCycles;

  assign Done = holdDone | pulseDone;

  prog_sequencer #(.NUM_PROGS(NP), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .Done(Done),
    .Start(Start), .ProgIdx(ProgIdx), .Busy(Busy),
    .ResultValid(ResultValid), .ResultProg(ResultProg), .ResultCycles(ResultCycles),
    .AllDone(AllDone), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct { int prog; int cycles; } expResT;
  typedef struct { int delay; bit hold; } vecT;

  expResT expQ[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int runId = 0;
  int doneDelay = -1;
  int expGap = 0;
  int resultsSeen = 0;
  int startsTotal = 0;
  int firstStartCyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Core model: raises Done so it is sampled doneDelay RUN edges after the first RUN edge
  initial begin
    int coreRun;
    int coreProg;
    coreRun = -1;
    coreProg = 0;
    forever begin
      @(negedge Clk);
      if (Start && !Reset && (doneDelay >= 0 || holdDone)) begin
        if (coreRun != runId) begin
          coreRun = runId;
          coreProg = 0;
        end
        coreProg++;
        if (holdDone) begin
          expQ.push_back('{coreProg, 0});
        end else begin
          expQ.push_back('{coreProg, doneDelay});
          repeat (doneDelay + 1) @(posedge Clk);
          #1 pulseDone = 1'b1;
          @(posedge Clk);
          #1 pulseDone = 1'b0;
        end
      end
    end
  end

  // Monitor: Start width/spacing and result scoreboard
  initial begin
    int monRun;
    int monStarts;
    int lastStartCyc;
    logic prevStart;
    expResT e;
    monRun = -1;
    monStarts = 0;
    lastStartCyc = 0;
    prevStart = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prevStart = 1'b0;
      end else begin
        if (monRun != runId) begin
          monRun = runId;
          monStarts = 0;
        end
        if (Start) begin
          check("start_width", int'(prevStart), 0);
          if (monStarts > 0) check("start_gap", cyc - lastStartCyc, expGap);
          else firstStartCyc = cyc;
          lastStartCyc = cyc;
          monStarts++;
          startsTotal++;
        end
        prevStart = Start;
        if (ResultValid) begin
          resultsSeen++;
          if (expQ.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = expQ.pop_front();
            check("result_prog", int'(ResultProg), e.prog);
            check("result_cycles", int'(ResultCycles), e.cycles);
          end
        end
      end
    end
  end

  initial begin
    vecT vecs[5];
    int r0, s0, d, expLen;
    bit never;

    vecs[0] = '{5, 1'b0};
    vecs[1] = '{0, 1'b1};
    vecs[2] = '{TO - 1, 1'b0};
    vecs[3] = '{-1, 1'b0};
    vecs[4] = '{2, 1'b0};

    // Reset held with Go high
    repeat (3) @(negedge Clk);
    check("rst_start", int'(Start), 0);
    check("rst_progidx", int'(ProgIdx), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_rvalid", int'(ResultValid), 0);
    check("rst_rprog", int'(ResultProg), 0);
    check("rst_rcycles", int'(ResultCycles), 0);
    check("rst_alldone", int'(AllDone), 0);
    check("rst_error", int'(Error), 0);
    Go = 1'b0;
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      check("idle_start", int'(Start), 0);
      check("idle_busy", int'(Busy), 0);
    end

    // Table of Done behaviours
    foreach (vecs[i]) begin
      runId++;
      never = !vecs[i].hold && vecs[i].delay < 0;
      d = vecs[i].hold ? 0 : vecs[i].delay;
      doneDelay = vecs[i].hold ? -1 : vecs[i].delay;
      holdDone = vecs[i].hold;
      expGap = 3 + d;
      r0 = resultsSeen;
      s0 = startsTotal;
      Go = 1'b1;
      for (int k = 0; k < 400; k++) begin
        @(negedge Clk);
        if (AllDone) break;
      end
      check("alldone_reached", int'(AllDone), 1);
      expLen = never ? 1 + TO : NP * (3 + d) - 1;
      check("seq_length", cyc - firstStartCyc, expLen);
      check("error_flag", int'(Error), int'(never));
      check("final_progidx", int'(ProgIdx), never ? 1 : NP);
      check("finish_busy", int'(Busy), 0);
      check("result_count", resultsSeen - r0, never ? 0 : NP);
      check("start_count", startsTotal - s0, never ? 1 : NP);
      check("queue_empty", expQ.size(), 0);
      Go = 1'b0;
      holdDone = 1'b0;
      repeat (3) @(negedge Clk);
      check("back_idle_alldone", int'(AllDone), 0);
      check("back_idle_progidx", int'(ProgIdx), 0);
    end

    // Reset during RUN of program 2, Go kept high
    runId++;
    doneDelay = 3;
    expGap = 6;
    Go = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (ProgIdx == 4'd2 && Busy && !Start) break;
    end
    check("reached_prog2_run", int'(ProgIdx), 2);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_start", int'(Start), 0);
    check("async_rst_busy", int'(Busy), 0);
    check("async_rst_progidx", int'(ProgIdx), 0);
    repeat (6) @(posedge Clk);
    expQ.delete();
    runId++;
    r0 = resultsSeen;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("restart_start", int'(Start), 1);
    check("restart_progidx", int'(ProgIdx), 1);
    for (int k = 0; k < 400; k++) begin
      @(negedge Clk);
      if (AllDone) break;
    end
    check("restart_alldone", int'(AllDone), 1);
    check("restart_results", resultsSeen - r0, NP);
    check("restart_error", int'(Error), 0);

    // FINISH with Go held: no relaunch; Go low then high relaunches
    s0 = startsTotal;
    repeat (10) @(negedge Clk);
    check("no_auto_relaunch", startsTotal - s0, 0);
    check("finish_held", int'(AllDone), 1);
    Go = 1'b0;
    repeat (2) @(negedge Clk);
    runId++;
    Go = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (Start) break;
    end
    check("relaunch_start", int'(Start), 1);
    for (int k = 0; k < 400; k++) begin
      @(negedge Clk);
      if (AllDone) break;
    end
    check("relaunch_alldone", int'(AllDone), 1);
    check("final_queue_empty", expQ.size(), 0);
    Go = 1'b0;
    repeat (3) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
